// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: store sizes, store opcodes
// and the byte-address to word-index mapping.
package mips_mem_pkg;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Upper address bits beyond the array are masked off, so addresses alias.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned addr_w);
        return (byte_addr >> 2) & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational store steering: byte enables, lane-aligned data and the
// alignment/legality decision for sw/sh/sb.
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic        we_DM,
    input  logic [1:0]  st_sig,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_aligned,
    output logic        legal
);

    logic [3:0] raw_en_s;

    // Decode size and low address bits into lanes; legality ignores we_DM.
    always_comb begin
        raw_en_s      = 4'b0000;
        wdata_aligned = 32'h0000_0000;
        legal         = 1'b0;
        case (st_sig)
            ST_WORD: begin
                legal         = (addr_lo == 2'b00);
                raw_en_s      = 4'b1111;
                wdata_aligned = wdata;
            end
            ST_HALF: begin
                legal = ~addr_lo[0];
                if (addr_lo[1]) begin
                    raw_en_s      = 4'b1100;
                    wdata_aligned = {wdata[15:0], 16'h0000};
                end else begin
                    raw_en_s      = 4'b0011;
                    wdata_aligned = {16'h0000, wdata[15:0]};
                end
            end
            ST_BYTE: begin
                legal         = 1'b1;
                raw_en_s      = 4'b0001 << addr_lo;
                wdata_aligned = {4{wdata[7:0]}};
            end
            default: begin
                legal         = 1'b0;
                raw_en_s      = 4'b0000;
                wdata_aligned = 32'h0000_0000;
            end
        endcase
    end

    assign byte_en = (we_DM && legal) ? raw_en_s : 4'b0000;

endmodule

// File: rtl/data_mem_store.sv
// MEM-stage data memory: byte/half/word stores with lane merging, combinational
// word read, store counter and registered misalignment reporting.
module data_mem_store
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_DM,
    input  logic [1:0]       st_sig,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             align_err,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] idx_s;
    logic [3:0]        byte_en_s;
    logic [31:0]       wdata_aligned_s;
    logic              legal_s;
    logic              commit_s;
    logic              reject_s;
    logic              align_err_r;
    logic [31:0]       err_addr_r;
    logic [CNT_W-1:0]  store_cnt_r;

    store_lane_merge u_merge (
        .we_DM         (we_DM),
        .st_sig        (st_sig),
        .addr_lo       (addr[1:0]),
        .wdata         (wdata),
        .byte_en       (byte_en_s),
        .wdata_aligned (wdata_aligned_s),
        .legal         (legal_s)
    );

    assign idx_s    = ADDR_W'(word_index(addr, ADDR_W));
    assign commit_s = we_DM & legal_s;
    assign reject_s = we_DM & ~legal_s;
    assign rdata    = mem_r[idx_s];

    // Memory array: full clear on reset, otherwise per-lane merge of enabled bytes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_aligned_s[8*b +: 8];
                end
            end
        end
    end

    // Committed-store counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            store_cnt_r <= '0;
        end else if (commit_s) begin
            store_cnt_r <= store_cnt_r + CNT_W'(1);
        end
    end

    // Rejected-store reporting: one-cycle pulse, address held until the next reject.
    always_ff @(posedge clk) begin
        if (!reset) begin
            align_err_r <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
        end else begin
            align_err_r <= reject_s;
            if (reject_s) begin
                err_addr_r <= addr;
            end
        end
    end

    assign align_err = align_err_r;
    assign err_addr  = err_addr_r;
    assign store_cnt = store_cnt_r;

endmodule

// File: doc/data_mem_store.md
Name: data_mem_store

Overview:
- Data memory for the MEM stage of the pipelined MIPS CPU.
- Consumes the MEM-stage store controls (we_DM, st_sig) and the ALU-computed address and store data.
- Performs byte, halfword and word stores with lane merging and an alignment check.
- Provides the full aligned word combinationally for the MEM/WB register; load extension happens in WB.

Parameters:
- ADDR_W, 10, number of word-index bits; memory holds 2^ADDR_W 32-bit words.
- CNT_W, 32, width of the store-event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- we_DM  input  1  store request in MEM stage.
- st_sig  input  2  store size: 00 word, 01 halfword, 10 byte, 11 illegal.
- addr  input  32  byte address from EX/MEM.
- wdata  input  32  store data from EX/MEM (forwarded value); the low bytes are significant for sb/sh.
- rdata  output  32  word at addr[ADDR_W+1:2], combinational.
- align_err  output  1  registered one-cycle pulse: the previous cycle's store was rejected.
- err_addr  output  32  byte address of the most recent rejected store.
- store_cnt  output  CNT_W  count of committed stores.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All memory words clear to 0; align_err, err_addr and store_cnt clear to 0.
  - Reset overrides any store presented in the same cycle; that store is dropped.
- Index and addressing:
  - Word index is addr[ADDR_W+1:2]; addr[31:ADDR_W+2] are ignored, so out-of-range addresses alias and wrap.
  - Read: rdata = mem[index], purely combinational.
  - Same-cycle read of a word being written returns the OLD value; the new value is visible from the next cycle.
- Alignment / legality (evaluated when we_DM==1):
  - word (00): addr[1:0] must be 00.
  - half (01): addr[0] must be 0.
  - byte (10): always legal.
  - st_sig 11: always illegal.
- Legal store, at the rising edge with reset==1:
  - Word: all four bytes written with wdata.
  - Half: addr[1]==0 writes bytes[1:0] with wdata[15:0]; addr[1]==1 writes bytes[3:2] with wdata[15:0].
  - Byte: lane addr[1:0] is written with wdata[7:0].
  - Unwritten bytes of the word hold their value.
  - store_cnt increments by 1 and wraps from all-ones to 0.
- Illegal store: memory unchanged; store_cnt unchanged. At the next edge align_err=1 and err_addr=addr.
- align_err timing:
  - align_err is 0 in any cycle not following an illegal store.
  - Back-to-back illegal stores hold align_err high and update err_addr each cycle.
- err_addr holds its value until the next illegal store or reset.
- we_DM==0: no write and no counter change regardless of st_sig, addr or wdata.
- Endianness: little-endian lanes, byte 0 = bits[7:0].
- Latency: write takes effect 1 cycle after presentation; read has 0 latency.
- No stall or handshake: one store per cycle is accepted unconditionally.

Decomposition:
- Shared package mips_mem_pkg holds:
  - ST_WORD=2'b00, ST_HALF=2'b01, ST_BYTE=2'b10;
  - opcodes OP_SB=6'b101000, OP_SH=6'b101001, OP_SW=6'b101011;
  - function/constant for the word-index slice.
- Sub-module store_lane_merge, purely combinational:
  - inputs: st_sig, addr[1:0], wdata, we_DM.
  - outputs: byte_en[3:0], lane-aligned wdata_aligned[31:0], legal.
- Top module holds the memory array, the counter and the error registers.

Test Plan:
- Reset then reads: hold reset=0 for 2 cycles with we_DM=1 sw addr=0x0 wdata=0xDEADBEEF -> rdata(addr 0)=0x00000000, store_cnt=0, align_err=0.
- Word store/read-during-write:
  - sw addr=0x10 wdata=0x11223344 -> same cycle rdata=0x00000000.
  - Next cycle rdata=0x11223344, store_cnt=1.
- Byte lanes:
  - After word 0x11223344 at 0x10: sb addr=0x12 wdata=0x000000AA -> word 0x11AA3344.
  - Then sh addr=0x10 wdata=0x0000BEEF -> word 0x11AABEEF, store_cnt=3.
- Misaligned stores:
  - sw addr=0x21 -> next cycle align_err=1, err_addr=0x21, word 0x20 unchanged, store_cnt unchanged.
  - Then sh addr=0x23 -> align_err stays 1, err_addr=0x23.
  - Idle cycle -> align_err=0, err_addr=0x23.
- Illegal/idle:
  - st_sig=11 with we_DM=1 addr=0x30 -> no write, align_err pulse.
  - we_DM=0 with st_sig=00 addr=0x30 wdata=0xFFFFFFFF -> mem[0x30] stays 0, no pulse.
- Aliasing and counter wrap:
  - With ADDR_W=10, sw addr=0x1004 wdata=0x5 -> rdata at addr 0x4 reads 0x5.
  - With CNT_W=2, 4 legal stores -> store_cnt returns to 0.
